snd_fill: RTL and testbench
===========================

Name: snd_fill

Overview:
- Producer side of the sound sample FIFO. Reads 32-bit PCM words from sound memory between a programmed start address and end address, inclusive.
- Formats each word into stereo frames {R[15:0], L[15:0]} and pushes them into the sample FIFO.
- The FIFO's read side feeds the volume stage. This block also drives that stage's USED qualifier.
- Supports stereo or packed-mono source data, one-shot or looped playback, and abort.

Parameters:
- AW, 16, sound memory word-address width.

Ports:
- CLK  in  1  system clock
- RSTN  in  1  synchronous active-low reset
- START  in  1  one-cycle pulse: begin playback at START_ADDR
- STOP  in  1  one-cycle pulse: abort playback
- LOOP  in  1  1 = wrap to START_ADDR after END_ADDR; sampled every word boundary
- MONO  in  1  1 = memory word holds two mono samples {s1,s0}; latched at START
- START_ADDR  in  AW  first word address; latched at START
- END_ADDR  in  AW  last word address, inclusive; latched at START
- MEM_RD  out  1  memory read strobe
- MEM_ADDR  out  AW  memory word address
- MEM_RDATA  in  32  read data, valid exactly 1 cycle after MEM_RD
- FIFO_FULL  in  1  FIFO cannot accept a write this cycle
- FIFO_WR_EN  out  1  FIFO write strobe
- FIFO_DIN  out  32  frame {R,L}
- USED  out  1  high while playing (any state except IDLE)
- DONE  out  1  one-cycle pulse when one-shot playback completes or a bad range is rejected

Behaviour:
- Reset (RSTN=0 at CLK edge) forces:
  - state IDLE
  - MEM_RD=0, MEM_ADDR=0
  - FIFO_WR_EN=0, FIFO_DIN=0
  - USED=0, DONE=0
  - all latched config = 0
- Reset takes effect mid-operation. Any held word is discarded and no further writes occur.
- States: IDLE, READ, WAIT, PUSH0, PUSH1.
- IDLE:
  - On START, latch START_ADDR, END_ADDR and MONO, and set the address counter to START_ADDR.
  - If END_ADDR < START_ADDR: stay in IDLE, pulse DONE the next cycle, and issue no reads.
  - Otherwise go to READ.
- READ: MEM_RD=1 for exactly one cycle with MEM_ADDR=counter, then go to WAIT.
- WAIT: capture MEM_RDATA into the hold register, then go to PUSH0.
- PUSH0:
  - While FIFO_FULL=1, FIFO_WR_EN=0 and the state holds.
  - Otherwise FIFO_WR_EN=1 for one cycle with FIFO_DIN set as follows:
    - stereo: hold[31:0]
    - mono: {hold[15:0], hold[15:0]}
  - After the write, a mono word goes to PUSH1. A stereo word goes to the end-of-word step.
- PUSH1 (mono only): same FULL handshake, with FIFO_DIN = {hold[31:16], hold[31:16]}, then go to the end-of-word step.
- End-of-word step (taken in the same cycle as the last write):
  - If counter != END: counter+1, go to READ.
  - If counter == END and LOOP=1: counter=START, go to READ. No DONE.
  - If counter == END and LOOP=0: go to IDLE, DONE=1 for one cycle.
- Counter arithmetic is AW-bit. END = all-ones is legal and needs no wrap past it.
- FIFO_WR_EN is never asserted while FIFO_FULL=1 in the same cycle. Each frame is written exactly once.
- Frame order is preserved. No gaps are inserted except while stalled on FULL.
- STOP, in any non-IDLE state:
  - Next state IDLE; USED falls the next cycle.
  - A pending frame is not written. An in-flight MEM_RDATA is ignored.
  - No DONE pulse.
- START while not IDLE restarts from the newly latched addresses. The pending word is discarded.
- START and STOP in the same cycle: STOP wins, the result is IDLE, and no config is latched.
- USED = (state != IDLE), registered.
- Throughput: a stereo word takes at least 3 cycles; a mono word takes at least 4 cycles.

Test Plan:
- Stereo one-shot: START_ADDR=0x10, END_ADDR=0x12, mem[0x10..0x12]=0x11112222/0x33334444/0x55556666, FULL=0.
  - Exactly 3 writes in that order.
  - DONE pulses once, 1 cycle after the 3rd write.
  - USED high from the cycle after START until the cycle after DONE.
- Mono: MONO=1, single word 0xAAAA5555.
  - Writes 0x55555555 then 0xAAAAAAAA.
  - DONE after the second write.
- Backpressure: hold FULL=1 for 10 cycles in PUSH0.
  - No FIFO_WR_EN during the stall.
  - Exactly one write of the held word in the cycle FULL drops.
  - No duplication and no loss.
- Loop and stop: LOOP=1, range 0x0..0x1.
  - Write sequence mem0, mem1, mem0, mem1...
  - MEM_ADDR wraps 1 to 0, with no DONE.
  - STOP mid-PUSH0: no further writes, USED=0 the next cycle, no DONE.
- Bad range and collisions:
  - START_ADDR=5, END_ADDR=4: DONE one cycle later, no MEM_RD, USED stays 0.
  - START and STOP in the same cycle while playing: IDLE, no DONE.
- Reset mid-operation: RSTN=0 during WAIT. All outputs are 0 the next cycle, and no write follows on RSTN release.

Source files
------------

// File: rtl/snd_fill.sv
// Sound-sample FIFO producer: walks sound memory from a start to an end word address,
// formats each 32-bit word as stereo {R,L} frames (or two duplicated mono frames) and pushes them.
module snd_fill #(
    parameter int AW = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic          STOP,
    input  logic          LOOP,
    input  logic          MONO,
    input  logic [AW-1:0] START_ADDR,
    input  logic [AW-1:0] END_ADDR,
    output logic          MEM_RD,
    output logic [AW-1:0] MEM_ADDR,
    input  logic [31:0]   MEM_RDATA,
    input  logic          FIFO_FULL,
    output logic          FIFO_WR_EN,
    output logic [31:0]   FIFO_DIN,
    output logic          USED,
    output logic          DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PUSH0,
        S_PUSH1
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_start;
    logic [AW-1:0] r_end;
    logic          r_mono;
    logic [31:0]   r_hold;
    logic          r_done;

    logic          w_wr_en;
    logic [31:0]   w_din;
    logic          w_eow;
    logic          w_adv;
    logic          w_load;
    logic          w_bad;
    logic          w_done;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        w_next  = r_state;
        w_wr_en = 1'b0;
        w_din   = '0;
        w_eow   = 1'b0;
        w_done  = 1'b0;
        w_bad   = (END_ADDR < START_ADDR);
        w_load  = START && !STOP;

        case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_READ:  w_next = S_WAIT;
            S_WAIT:  w_next = S_PUSH0;
            S_PUSH0: begin
                w_din = r_mono ? {r_hold[15:0], r_hold[15:0]} : r_hold;
                if (!FIFO_FULL) begin
                    w_wr_en = 1'b1;
                    if (r_mono) begin
                        w_next = S_PUSH1;
                    end else begin
                        w_eow = 1'b1;
                    end
                end
            end
            S_PUSH1: begin
                w_din = {r_hold[31:16], r_hold[31:16]};
                if (!FIFO_FULL) begin
                    w_wr_en = 1'b1;
                    w_eow   = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase

        // End-of-word decision rides on the cycle of the word's last write.
        if (w_eow) begin
            if ((r_addr != r_end) || LOOP) begin
                w_next = S_READ;
            end else begin
                w_next = S_IDLE;
                w_done = 1'b1;
            end
        end

        // Abort beats restart; both drop any frame still pending.
        if (STOP) begin
            w_next  = S_IDLE;
            w_wr_en = 1'b0;
            w_done  = 1'b0;
        end else if (START) begin
            w_wr_en = 1'b0;
            w_done  = w_bad;
            w_next  = w_bad ? S_IDLE : S_READ;
        end

        w_adv = w_eow && !START && !STOP;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_start <= '0;
            r_end   <= '0;
            r_mono  <= 1'b0;
            r_hold  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done;

            if (w_load) begin
                r_start <= START_ADDR;
                r_end   <= END_ADDR;
                r_mono  <= MONO;
                r_addr  <= START_ADDR;
            end else if (w_adv) begin
                // Compare before incrementing, so END = all-ones never wraps the counter.
                r_addr <= (r_addr == r_end) ? r_start : r_addr + AW'(1);
            end

            if (r_state == S_WAIT) begin
                r_hold <= MEM_RDATA;
            end
        end
    end

    assign MEM_RD     = (r_state == S_READ);
    assign MEM_ADDR   = r_addr;
    assign FIFO_WR_EN = w_wr_en;
    assign FIFO_DIN   = w_din;
    assign USED       = (r_state != S_IDLE);
    assign DONE       = r_done;

endmodule

// File: tb/tb_snd_fill.sv
// Directed bench for snd_fill: memory model with 1-cycle read latency, FIFO write monitor,
// and immediate-assertion checks against hand-computed expectations.
module tb_snd_fill;

    localparam int AW = 16;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          START = 1'b0;
    logic          STOP = 1'b0;
    logic          LOOP = 1'b0;
    logic          MONO = 1'b0;
    logic [AW-1:0] START_ADDR = '0;
    logic [AW-1:0] END_ADDR = '0;
    logic          MEM_RD;
    logic [AW-1:0] MEM_ADDR;
    logic [31:0]   MEM_RDATA;
    logic          FIFO_FULL = 1'b0;
    logic          FIFO_WR_EN;
    logic [31:0]   FIFO_DIN;
    logic          USED;
    logic          DONE;

    snd_fill #(.AW(AW)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .START      (START),
        .STOP       (STOP),
        .LOOP       (LOOP),
        .MONO       (MONO),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR),
        .MEM_RD     (MEM_RD),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_RDATA  (MEM_RDATA),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_WR_EN (FIFO_WR_EN),
        .FIFO_DIN   (FIFO_DIN),
        .USED       (USED),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    // Sound memory: data valid exactly one cycle after the strobe, garbage otherwise.
    logic [31:0] mem [0:255];
    always @(posedge CLK) begin
        MEM_RDATA <= MEM_RD ? mem[MEM_ADDR[7:0]] : 32'hDEAD_BEEF;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [31:0]   wr_q[$];
    logic [AW-1:0] rd_q[$];
    logic [31:0]   exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    int full_viol = 0;

    always @(negedge CLK) begin
        if (FIFO_WR_EN) begin
            wr_q.push_back(FIFO_DIN);
            last_wr_cyc = cyc;
            if (FIFO_FULL) full_viol++;
        end
        if (MEM_RD) rd_q.push_back(MEM_ADDR);
        if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        done_cnt = 0;
        full_viol = 0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, " write count"}, 64'(wr_q.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size(); i++) begin
            if (i < wr_q.size()) check($sformatf("%s write %0d", tag, i), 64'(wr_q[i]), 64'(exp_wr[i]));
        end
    endtask

    task automatic check_reads(input string tag);
        check({tag, " read count"}, 64'(rd_q.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size(); i++) begin
            if (i < rd_q.size()) check($sformatf("%s read %0d", tag, i), 64'(rd_q[i]), 64'(exp_rd[i]));
        end
    endtask

    task automatic wait_done(input string tag, input int max);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max) begin
            tick();
            n++;
        end
        check({tag, " done seen"}, 64'(done_cnt), 64'd1);
    endtask

    function automatic logic [63:0] out_vec();
        return {12'h0, MEM_RD, MEM_ADDR, FIFO_WR_EN, FIFO_DIN, USED, DONE};
    endfunction

    task automatic start_play(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
        START_ADDR = sa;
        END_ADDR   = ea;
        START      = 1'b1;
        tick();
        START      = 1'b0;
    endtask

    int t0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hF000_0000 | i;
        mem[8'h00] = 32'hA0A0_A0A0;
        mem[8'h01] = 32'hB1B1_B1B1;
        mem[8'h10] = 32'h1111_2222;
        mem[8'h11] = 32'h3333_4444;
        mem[8'h12] = 32'h5555_6666;
        mem[8'h20] = 32'hAAAA_5555;
        mem[8'h30] = 32'h1234_5678;
        mem[8'hFF] = 32'hCAFE_F00D;

        // Reset state
        tick();
        tick();
        check("reset outputs", out_vec(), 64'h0);
        RSTN = 1'b1;
        tick();

        // Stereo one-shot 0x10..0x12
        clear_mon();
        t0 = cyc;
        start_play(16'h10, 16'h12);
        check("stereo used after start", 64'(USED), 64'd1);
        repeat (8) tick();
        check("stereo used at last write", 64'(USED), 64'd1);
        tick();
        check("stereo done pulse", 64'(DONE), 64'd1);
        tick();
        check("stereo done cleared", 64'(DONE), 64'd0);
        check("stereo used dropped", 64'(USED), 64'd0);
        exp_wr = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        check_writes("stereo");
        exp_rd = '{16'h10, 16'h11, 16'h12};
        check_reads("stereo");
        check("stereo done count", 64'(done_cnt), 64'd1);
        check("stereo done after write", 64'(done_cyc - last_wr_cyc), 64'd1);
        check("stereo done cycle", 64'(done_cyc - t0), 64'd10);

        // Mono single word; MONO dropped after START to show it is latched
        clear_mon();
        t0 = cyc;
        MONO = 1'b1;
        start_play(16'h20, 16'h20);
        MONO = 1'b0;
        wait_done("mono", 20);
        exp_wr = '{32'h5555_5555, 32'hAAAA_AAAA};
        check_writes("mono");
        check("mono done after write", 64'(done_cyc - last_wr_cyc), 64'd1);
        check("mono done cycle", 64'(done_cyc - t0), 64'd5);

        // Backpressure: FULL held for 10 cycles in PUSH0
        clear_mon();
        start_play(16'h30, 16'h30);
        FIFO_FULL = 1'b1;
        tick();
        tick();
        #1;
        check("stall wr_en", 64'(FIFO_WR_EN), 64'd0);
        check("stall used", 64'(USED), 64'd1);
        repeat (10) tick();
        check("stall no writes", 64'(wr_q.size()), 64'd0);
        FIFO_FULL = 1'b0;
        #1;
        check("release wr_en", 64'(FIFO_WR_EN), 64'd1);
        check("release din", 64'(FIFO_DIN), 64'h1234_5678);
        tick();
        check("release done", 64'(DONE), 64'd1);
        tick();
        exp_wr = '{32'h1234_5678};
        check_writes("backpressure");
        check("no write while full", 64'(full_viol), 64'd0);

        // Loop over 0x0..0x1, then STOP in PUSH0 of the fifth word
        clear_mon();
        LOOP = 1'b1;
        start_play(16'h0, 16'h1);
        repeat (14) tick();
        check("loop writes before stop", 64'(wr_q.size()), 64'd4);
        STOP = 1'b1;
        #1;
        check("stop wr_en", 64'(FIFO_WR_EN), 64'd0);
        tick();
        STOP = 1'b0;
        LOOP = 1'b0;
        check("stop used", 64'(USED), 64'd0);
        check("stop done", 64'(DONE), 64'd0);
        repeat (5) tick();
        exp_wr = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hA0A0_A0A0, 32'hB1B1_B1B1};
        check_writes("loop");
        exp_rd = '{16'h0, 16'h1, 16'h0, 16'h1, 16'h0};
        check_reads("loop");
        check("loop no done", 64'(done_cnt), 64'd0);

        // Bad range START=5 END=4
        clear_mon();
        start_play(16'h5, 16'h4);
        check("bad range done", 64'(DONE), 64'd1);
        check("bad range used", 64'(USED), 64'd0);
        tick();
        check("bad range done cleared", 64'(DONE), 64'd0);
        check("bad range used later", 64'(USED), 64'd0);
        check("bad range no reads", 64'(rd_q.size()), 64'd0);

        // START and STOP together while playing: STOP wins, nothing latched
        clear_mon();
        start_play(16'h10, 16'h12);
        tick();
        START_ADDR = 16'h40;
        END_ADDR   = 16'h41;
        START      = 1'b1;
        STOP       = 1'b1;
        tick();
        START = 1'b0;
        STOP  = 1'b0;
        check("start+stop used", 64'(USED), 64'd0);
        check("start+stop addr kept", 64'(MEM_ADDR), 64'h10);
        repeat (4) tick();
        check("start+stop no writes", 64'(wr_q.size()), 64'd0);
        check("start+stop no done", 64'(done_cnt), 64'd0);
        check("start+stop reads", 64'(rd_q.size()), 64'd1);

        // Restart while playing discards the pending word
        clear_mon();
        start_play(16'h10, 16'h12);
        tick();
        start_play(16'h20, 16'h20);
        wait_done("restart", 20);
        exp_wr = '{32'hAAAA_5555};
        check_writes("restart");
        exp_rd = '{16'h10, 16'h20};
        check_reads("restart");

        // Reset during WAIT
        clear_mon();
        start_play(16'h10, 16'h12);
        tick();
        RSTN = 1'b0;
        tick();
        check("mid reset outputs", out_vec(), 64'h0);
        RSTN = 1'b1;
        repeat (6) tick();
        check("mid reset no writes", 64'(wr_q.size()), 64'd0);
        check("mid reset reads", 64'(rd_q.size()), 64'd1);
        check("mid reset used", 64'(USED), 64'd0);
        check("mid reset no done", 64'(done_cnt), 64'd0);

        // END at all-ones address
        clear_mon();
        start_play(16'hFFFF, 16'hFFFF);
        wait_done("top addr", 20);
        tick();
        exp_wr = '{32'hCAFE_F00D};
        check_writes("top addr");
        exp_rd = '{16'hFFFF};
        check_reads("top addr");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
